// File: rtl/traffic_pkg.sv
// Definitions shared by traffic_light and traffic_light_monitor: lamp phases,
// monitor states, fault codes and the legal phase order.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_NONE,
    PH_RED,
    PH_YELLOW,
    PH_GREEN,
    PH_MULTI
  } phase_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FAULT
  } mon_state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ONEHOT  = 3'd1;
  localparam logic [2:0] FC_ILLEGAL = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_LONG    = 3'd4;

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      PH_GREEN:  n = PH_YELLOW;
      PH_YELLOW: n = PH_RED;
      PH_RED:    n = PH_GREEN;
      default:   n = PH_NONE;
    endcase
    return n;
  endfunction

  // Lamp vector is ordered {red, yellow, green}.
  function automatic phase_e decode_lamps(input logic [2:0] ryg);
    phase_e p;
    case (ryg)
      3'b000:  p = PH_NONE;
      3'b100:  p = PH_RED;
      3'b010:  p = PH_YELLOW;
      3'b001:  p = PH_GREEN;
      default: p = PH_MULTI;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// Half-period toggler for the fault flash. 'flash' is the level the lamp takes
// on the current edge; a rising enable restarts the pattern from "lit, count 0".
module flash_timer #(
  parameter int FLASH_HALF = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic flash
);

  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [HW-1:0] half_q, half_d, base_half;
  logic          lvl_q, lvl_d, base_lvl;
  logic          en_q;
  logic          rise;

  always_comb begin
    rise      = en & ~en_q;
    base_half = rise ? '0 : half_q;
    base_lvl  = rise ? 1'b1 : lvl_q;
    half_d    = half_q;
    lvl_d     = lvl_q;
    if (en) begin
      if (base_half == HW'(FLASH_HALF - 1)) begin
        half_d = '0;
        lvl_d  = ~base_lvl;
      end else begin
        half_d = base_half + HW'(1);
        lvl_d  = base_lvl;
      end
    end
  end

  assign flash = lvl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= '0;
      lvl_q  <= 1'b1;
      en_q   <= 1'b0;
    end else begin
      half_q <= half_d;
      lvl_q  <= lvl_d;
      en_q   <= en;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between traffic_light and the lamp drivers: checks one-hot,
// phase order and phase durations, and forces flashing red on any violation.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_RED    = 4,
  parameter int MAX_PHASE  = 16,
  parameter int FLASH_HALF = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red_in,
  input  logic             yellow_in,
  input  logic             green_in,
  input  logic             fault_clr,
  output logic             red_out,
  output logic             yellow_out,
  output logic             green_out,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] phase_cnt
);

  mon_state_e       state_q, state_d;
  phase_e           cur_q, cur_d;
  phase_e           ph_in;
  logic [2:0]       in_q, in_d;
  logic [2:0]       lamps_q, lamps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] min_hold;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       chk_code;
  logic             flash;

  flash_timer #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ST_FAULT),
    .flash (flash)
  );

  always_comb begin
    in_d  = {red_in, yellow_in, green_in};
    ph_in = decode_lamps(in_q);
    case (cur_q)
      PH_GREEN:  min_hold = CNT_W'(MIN_GREEN);
      PH_YELLOW: min_hold = CNT_W'(MIN_YELLOW);
      default:   min_hold = CNT_W'(MIN_RED);
    endcase

    // Only the highest-priority violation is reported.
    chk_code = FC_NONE;
    if (ph_in == PH_NONE || ph_in == PH_MULTI)
      chk_code = FC_ONEHOT;
    else if (ph_in != cur_q && ph_in != next_phase(cur_q))
      chk_code = FC_ILLEGAL;
    else if (ph_in != cur_q && cnt_q < min_hold)
      chk_code = FC_SHORT;
    else if (ph_in == cur_q && cnt_q == CNT_W'(MAX_PHASE))
      chk_code = FC_LONG;

    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    code_d  = code_q;
    lamps_d = lamps_q;

    case (state_q)
      ST_INIT: begin
        lamps_d = 3'b100;
        if (ph_in != PH_NONE && ph_in != PH_MULTI) begin
          state_d = ST_RUN;
          cur_d   = ph_in;
          cnt_d   = CNT_W'(1);
          lamps_d = in_q;
        end
      end
      ST_RUN: begin
        if (chk_code != FC_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = chk_code;
          lamps_d = 3'b100;
        end else begin
          lamps_d = in_q;
          if (ph_in == cur_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cur_d = ph_in;
            cnt_d = CNT_W'(1);
          end
        end
      end
      ST_FAULT: begin
        lamps_d = {flash, 2'b00};
        if (fault_clr) begin
          state_d = ST_INIT;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          cnt_d   = '0;
          lamps_d = 3'b100;
        end
      end
      default: begin
        state_d = ST_INIT;
        lamps_d = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      in_q    <= 3'b000;
      cur_q   <= PH_NONE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      lamps_q <= 3'b100;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      lamps_q <= lamps_d;
    end
  end

  assign red_out    = lamps_q[2];
  assign yellow_out = lamps_q[1];
  assign green_out  = lamps_q[0];
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign phase_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: each stimulus cycle queues the
// output expected two edges later; a monitor pops and compares on its due edge.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int W = 15;
  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       red_in    = 1'b0;
  logic       yellow_in = 1'b0;
  logic       green_in  = 1'b0;
  logic       fault_clr = 1'b0;
  logic       red_out, yellow_out, green_out, fault;
  logic [2:0] fault_code;
  logic [7:0] phase_cnt;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  string        tag_q[$];
  int           edge_cnt = 0;
  int           n_vec    = 0;
  int           n_bad    = 0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .red_in     (red_in),
    .yellow_in  (yellow_in),
    .green_in   (green_in),
    .fault_clr  (fault_clr),
    .red_out    (red_out),
    .yellow_out (yellow_out),
    .green_out  (green_out),
    .fault      (fault),
    .fault_code (fault_code),
    .phase_cnt  (phase_cnt)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // One stimulus cycle; the expected values are those visible two edges on.
  task automatic cyc(input logic [2:0] lin, input logic clr, input logic r,
                     input logic [2:0] el, input logic ef, input logic [2:0] ec,
                     input int ecnt, input string tag);
    @(negedge clk);
    {red_in, yellow_in, green_in} = lin;
    fault_clr = clr;
    rst       = r;
    exp_q.push_back({el, ef, ec, 8'(ecnt)});
    due_q.push_back(edge_cnt + 2);
    tag_q.push_back(tag);
  endtask

  task automatic hold(input logic [2:0] l, input int n, input string tag);
    for (int i = 1; i <= n; i++) cyc(l, 1'b0, 1'b0, l, 1'b0, FC_NONE, i, tag);
  endtask

  // Clear is sampled directly, so the cycle before it already sees INIT.
  task automatic to_init();
    cyc(L_OFF, 1'b0, 1'b0, L_R, 1'b0, FC_NONE, 0, "clear");
    cyc(L_OFF, 1'b1, 1'b0, L_R, 1'b0, FC_NONE, 0, "clear");
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] got, want;
    string        tag;
    int           d;
    forever begin
      @(posedge clk);
      #1;
      while (due_q.size() > 0 && due_q[0] == edge_cnt) begin
        got  = {red_out, yellow_out, green_out, fault, fault_code, phase_cnt};
        want = exp_q.pop_front();
        d    = due_q.pop_front();
        tag  = tag_q.pop_front();
        n_vec++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s @edge %0d: got lamps=%b fault=%b code=%0d cnt=%0d, required lamps=%b fault=%b code=%0d cnt=%0d",
                   tag, d, got[14:12], got[11], got[10:8], got[7:0],
                   want[14:12], want[11], want[10:8], want[7:0]);
        end
      end
    end
  end

  // Driver
  initial begin
    repeat (2) cyc(L_OFF, 1'b0, 1'b1, L_R, 1'b0, FC_NONE, 0, "reset");
    repeat (5) cyc(L_OFF, 1'b0, 1'b0, L_R, 1'b0, FC_NONE, 0, "init_idle");
    cyc(3'b110, 1'b0, 1'b0, L_R, 1'b0, FC_NONE, 0, "init_multi");

    hold(L_G, 6, "legal_g");
    hold(L_Y, 3, "legal_y");
    hold(L_R, 5, "legal_r");
    hold(L_G, 6, "legal_g2");

    cyc(3'b110, 1'b0, 1'b0, L_R, 1'b1, FC_ONEHOT, 6, "not_onehot");
    // First flash cycle also carries a clear on the FAULT entry edge.
    for (int i = 1; i <= 11; i++)
      cyc(L_G, (i == 1), 1'b0, (((i / 3) % 2) == 0) ? L_R : L_OFF,
          1'b1, FC_ONEHOT, 6, "flash");
    to_init();
    cyc(L_OFF, 1'b1, 1'b0, L_R, 1'b0, FC_NONE, 0, "clr_held");
    cyc(L_OFF, 1'b0, 1'b0, L_R, 1'b0, FC_NONE, 0, "init_after_clr");

    hold(L_G, 2, "prio_g");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b1, FC_ILLEGAL, 2, "illegal_over_short");
    to_init();

    hold(L_G, 5, "short_g");
    hold(L_Y, 1, "short_y");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b1, FC_SHORT, 1, "too_short");
    to_init();

    hold(L_R, 16, "long_r");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b1, FC_LONG, 16, "too_long");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b1, FC_LONG, 16, "long_flash");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b1, FC_LONG, 16, "long_flash");
    cyc(L_R, 1'b0, 1'b0, L_OFF, 1'b1, FC_LONG, 16, "long_flash");
    cyc(L_R, 1'b0, 1'b0, L_R, 1'b0, FC_NONE, 0, "rst_mid_flash");
    cyc(L_OFF, 1'b0, 1'b1, L_R, 1'b0, FC_NONE, 0, "rst_mid_flash");
    hold(L_G, 2, "after_rst");

    @(negedge clk);
    {red_in, yellow_in, green_in} = L_OFF;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
